// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side dispatcher.
package fifo_pkg;

  typedef enum logic {RUN, FLUSH} dispatch_state_e;

  localparam int unsigned STAT_CNT_W = 16;

  function automatic logic [STAT_CNT_W-1:0] sat_inc(input logic [STAT_CNT_W-1:0] v);
    return (&v) ? v : v + STAT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first eligible lane at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N-1:0]    elig_i,
  input  logic            advance_i,
  input  logic            clear_i,
  output logic [N-1:0]    grant_o,
  output logic [PtrW-1:0] ptr_o
);

  logic [PtrW-1:0] ptr_q;
  logic [PtrW-1:0] win;
  logic [PtrW-1:0] ptr_nxt;
  logic            found;

  // Two passes: lanes at/after the pointer first, then the wrapped lanes below it.
  always_comb begin
    grant_o = '0;
    win     = ptr_q;
    found   = 1'b0;
    for (int j = 0; j < int'(N); j++) begin
      if (!found && elig_i[j] && (j >= int'(ptr_q))) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        win        = PtrW'(j);
      end
    end
    for (int j = 0; j < int'(N); j++) begin
      if (!found && elig_i[j] && (j < int'(ptr_q))) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        win        = PtrW'(j);
      end
    end
    if (int'(win) == int'(N) - 1) ptr_nxt = '0;
    else                          ptr_nxt = win + PtrW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (clear_i) begin
      ptr_q <= '0;
    end else if (advance_i && found) begin
      ptr_q <= ptr_nxt;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_rd_dispatch.sv
// Pops an upstream FIFO into per-lane one-word slots with round-robin lane selection.
// Optional per-lane transfer counters are enabled by FIFO_RD_DISPATCH_STAT_EN.
module fifo_rd_dispatch import fifo_pkg::*; #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned N_READERS = 2
) (
  input  logic                           i_rd_clk,
  input  logic                           i_rd_rstn,
  input  logic                           i_fifo_empty,
  input  logic [WIDTH-1:0]               i_fifo_rd_data,
  output logic                           o_fifo_rd_en,
  input  logic [N_READERS-1:0]           i_req,
  output logic [N_READERS-1:0]           o_vld,
  output logic [N_READERS*WIDTH-1:0]     o_data,
  input  logic [N_READERS-1:0]           i_rdy,
  input  logic                           i_flush,
`ifdef FIFO_RD_DISPATCH_STAT_EN
  output logic [N_READERS*STAT_CNT_W-1:0] o_stat_cnt,
`endif
  output logic                           o_busy
);

  localparam int unsigned RrPtrW = (N_READERS > 1) ? $clog2(N_READERS) : 1;

  dispatch_state_e                      state_q;
  logic [N_READERS-1:0]                 vld_q;
  logic [N_READERS-1:0][WIDTH-1:0]      data_q;
  logic [N_READERS-1:0]                 xfer, free, elig, grant;
  logic [RrPtrW-1:0]                    rr_ptr;
  logic                                 pop, load, ret_run;

  always_comb begin
    xfer    = vld_q & i_rdy;
    free    = ~vld_q | i_rdy;
    elig    = i_req & free;
    // Rd-enable is combinational, so reset must gate it explicitly.
    pop     = i_rd_rstn & ((state_q == FLUSH) ? ~i_fifo_empty : (~i_fifo_empty & (|elig)));
    load    = pop & (state_q == RUN) & ~i_flush;
    ret_run = (state_q == FLUSH) & i_fifo_empty;
  end

  rr_arbiter #(
    .N(N_READERS)
  ) u_arb (
    .clk_i    (i_rd_clk),
    .rst_ni   (i_rd_rstn),
    .elig_i   (elig),
    .advance_i(load),
    .clear_i  (ret_run),
    .grant_o  (grant),
    .ptr_o    (rr_ptr)
  );

  always_comb assert (32'(rr_ptr) < N_READERS);

  always_ff @(posedge i_rd_clk or negedge i_rd_rstn) begin
    if (!i_rd_rstn) begin
      state_q <= RUN;
    end else begin
      unique case (state_q)
        RUN:     if (i_flush)      state_q <= FLUSH;
        FLUSH:   if (i_fifo_empty) state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  always_ff @(posedge i_rd_clk or negedge i_rd_rstn) begin
    if (!i_rd_rstn) begin
      vld_q  <= '0;
      data_q <= '0;
    end else if ((state_q != RUN) || i_flush) begin
      vld_q <= '0;
    end else begin
      for (int k = 0; k < int'(N_READERS); k++) begin
        if (load && grant[k]) begin
          vld_q[k]  <= 1'b1;
          data_q[k] <= i_fifo_rd_data;
        end else if (xfer[k]) begin
          vld_q[k] <= 1'b0;
        end
      end
    end
  end

`ifdef FIFO_RD_DISPATCH_STAT_EN
  logic [N_READERS-1:0][STAT_CNT_W-1:0] stat_q;

  always_ff @(posedge i_rd_clk or negedge i_rd_rstn) begin
    if (!i_rd_rstn) begin
      stat_q <= '0;
    end else begin
      for (int k = 0; k < int'(N_READERS); k++) begin
        if (xfer[k]) stat_q[k] <= sat_inc(stat_q[k]);
      end
    end
  end

  assign o_stat_cnt = stat_q;
`endif

  assign o_fifo_rd_en = pop;
  assign o_vld        = vld_q;
  assign o_data       = data_q;
  assign o_busy       = (state_q == FLUSH);

endmodule

// File: tb/tb_fifo_rd_dispatch.sv
// Directed self-checking bench for fifo_rd_dispatch (WIDTH=8, N_READERS=2).
module tb_fifo_rd_dispatch;

  logic        clk = 1'b0;
  logic        rstn;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        rd_en;
  logic [1:0]  req, vld, rdy;
  logic [15:0] data;
  logic        flush, busy;
`ifdef FIFO_RD_DISPATCH_STAT_EN
  logic [31:0] stat_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [16];
  int  wr_ptr  = 0;
  int  rd_ptr  = 0;
  int  pop_cnt = 0;
  int  bad_pop = 0;
  int  base;
  bit  stream  = 1'b0;

  always #5 clk = ~clk;

  assign fifo_empty = stream ? 1'b0 : (rd_ptr == wr_ptr);
  assign fifo_data  = stream ? 8'h5A : mem[rd_ptr[3:0]];

  always @(posedge clk) begin
    if (rd_en) begin
      if (fifo_empty) bad_pop <= bad_pop + 1;
      else if (!stream) rd_ptr <= rd_ptr + 1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  fifo_rd_dispatch #(
    .WIDTH    (8),
    .N_READERS(2)
  ) dut (
    .i_rd_clk      (clk),
    .i_rd_rstn     (rstn),
    .i_fifo_empty  (fifo_empty),
    .i_fifo_rd_data(fifo_data),
    .o_fifo_rd_en  (rd_en),
    .i_req         (req),
    .o_vld         (vld),
    .o_data        (data),
    .i_rdy         (rdy),
    .i_flush       (flush),
`ifdef FIFO_RD_DISPATCH_STAT_EN
    .o_stat_cnt    (stat_cnt),
`endif
    .o_busy        (busy)
  );

  task automatic push(input logic [7:0] d);
    mem[wr_ptr[3:0]] = d;
    wr_ptr++;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rstn = 1'b0; req = 2'b11; rdy = 2'b11; flush = 1'b0;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    #12;
    check("rst_rd_en", rd_en, 1'b0);
    check("rst_vld", vld, 2'b00);
    check("rst_data", data, 16'h0000);
    check("rst_busy", busy, 1'b0);
    check("rst_ptr", dut.rr_ptr, 0);
    check("rst_pops", pop_cnt, 0);

    // Alternating grants, one pop per cycle
    @(negedge clk); rstn = 1'b1;
    #1 check("rr_rd_en0", rd_en, 1'b1);
    next(); check("rr_vld1", vld, 2'b01); check("rr_d0_11", data[7:0], 8'h11);
    check("rr_pops1", pop_cnt, 1); check("rr_ptr1", dut.rr_ptr, 1);
    next(); check("rr_vld2", vld, 2'b10); check("rr_d1_22", data[15:8], 8'h22);
    check("rr_pops2", pop_cnt, 2);
    next(); check("rr_vld3", vld, 2'b01); check("rr_d0_33", data[7:0], 8'h33);
    check("rr_pops3", pop_cnt, 3);
    next(); check("rr_vld4", vld, 2'b10); check("rr_d1_44", data[15:8], 8'h44);
    check("rr_pops4", pop_cnt, 4); check("rr_empty_rd_en", rd_en, 1'b0);
    next(); check("rr_vld5", vld, 2'b00); check("rr_ptr5", dut.rr_ptr, 0);

    // Back-pressure: lane0 holds 0xAA while not ready
    req = 2'b01; rdy = 2'b00; push(8'hAA);
    #1 check("bp_rd_en", rd_en, 1'b1);
    next(); check("bp_vld", vld, 2'b01); check("bp_d0", data[7:0], 8'hAA);
    check("bp_ptr", dut.rr_ptr, 1);
    push(8'hBB);
    repeat (3) begin
      #1 check("bp_hold_rd_en", rd_en, 1'b0);
      next(); check("bp_hold_d0", data[7:0], 8'hAA); check("bp_hold_vld", vld, 2'b01);
    end
    rdy = 2'b01;
    #1 check("bp_release_rd_en", rd_en, 1'b1);
    next(); check("bp_reload_vld", vld, 2'b01); check("bp_reload_d0", data[7:0], 8'hBB);
    req = 2'b00;
    next(); check("bp_drain_vld", vld, 2'b00); check("bp_drain_ptr", dut.rr_ptr, 1);

    // Empty FIFO: no pops, pointer frozen
    req = 2'b11; rdy = 2'b11;
    repeat (3) begin
      #1 check("empty_rd_en", rd_en, 1'b0);
      next(); check("empty_ptr", dut.rr_ptr, 1); check("empty_vld", vld, 2'b00);
    end

    // Flush with both slots full and three words queued
    rdy = 2'b00; push(8'h51); push(8'h52);
    next(); check("fl_fill1_vld", vld, 2'b10); check("fl_fill1_d1", data[15:8], 8'h51);
    next(); check("fl_fill2_vld", vld, 2'b11); check("fl_fill2_d0", data[7:0], 8'h52);
    push(8'h61); push(8'h62); push(8'h63);
    #1 check("fl_full_rd_en", rd_en, 1'b0);
    flush = 1'b1; base = pop_cnt;
    next(); flush = 1'b0;
    check("fl_entry_vld", vld, 2'b00); check("fl_entry_busy", busy, 1'b1);
    check("fl_entry_pops", pop_cnt, base);
    #1 check("fl_rd_en", rd_en, 1'b1);
    next(); check("fl_pop1", pop_cnt, base + 1); check("fl_busy1", busy, 1'b1);
    flush = 1'b1;
    next(); flush = 1'b0;
    check("fl_pop2", pop_cnt, base + 2); check("fl_busy2", busy, 1'b1);
    check("fl_vld2", vld, 2'b00);
    next(); check("fl_pop3", pop_cnt, base + 3); check("fl_busy3", busy, 1'b1);
    check("fl_rd_en_empty", rd_en, 1'b0);
    next(); check("fl_exit_busy", busy, 1'b0); check("fl_exit_ptr", dut.rr_ptr, 0);
    check("fl_exit_pops", pop_cnt, base + 3);
    push(8'h77);
    #1 check("fl_regrant_rd_en", rd_en, 1'b1);
    next(); check("fl_regrant_vld", vld, 2'b01); check("fl_regrant_d0", data[7:0], 8'h77);

    // Reset while lane1 holds a word
    push(8'h88);
    next(); check("rs_vld", vld, 2'b11); check("rs_d1", data[15:8], 8'h88);
    push(8'h99);
    @(negedge clk); rstn = 1'b0;
    #1 check("rs_vld_clr", vld, 2'b00); check("rs_ptr", dut.rr_ptr, 0);
    check("rs_rd_en", rd_en, 1'b0); check("rs_data", data, 16'h0000);
    check("rs_busy", busy, 1'b0);
    base = pop_cnt;
    next(); check("rs_hold_rd_en", rd_en, 1'b0); check("rs_hold_pops", pop_cnt, base);
    @(negedge clk); rstn = 1'b1; rdy = 2'b11;
    #1 check("rs_after_rd_en", rd_en, 1'b1);
    next(); check("rs_after_vld", vld, 2'b01); check("rs_after_d0", data[7:0], 8'h99);

`ifdef FIFO_RD_DISPATCH_STAT_EN
    // Continuous lane0 traffic: counter tracks then saturates
    req = 2'b01; rdy = 2'b01; stream = 1'b1;
    repeat (10) @(posedge clk);
    #1 check("stat_lane0_10", stat_cnt[15:0], 16'd10);
    check("stat_lane1_0", stat_cnt[31:16], 16'd0);
    repeat (65530) @(posedge clk);
    #1 check("stat_lane0_sat", stat_cnt[15:0], 16'hFFFF);
    stream = 1'b0; req = 2'b00;
    next();
`endif

    check("no_pop_when_empty", bad_pop, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
